phase_timer: RTL and testbench

Per-state phase timer for the train controller. It replaces fixed state-to-time selection with a programmable map from controller state to one of N preset durations. On every state change it loads the selected duration and counts it down on an external tick enable. It reports the selected preset, the remaining time and a one-cycle expiry pulse back to the controller FSM.

---
 rtl/train_pkg.sv | 19 +
 rtl/phase_map.sv | 42 ++++
 rtl/phase_timer.sv | 84 ++++++++
 tb/tb_phase_timer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/train_pkg.sv
// Shared train-controller definitions: state encodings, default phase map, time width.
package train_pkg;

  localparam int TIME_W = 19;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_DOORS  = 4'd3;
  localparam logic [3:0] ST_DEPART = 4'd4;

  // States whose default map entry is preset 0; every other state uses preset 1.
  localparam logic [15:0] DEFAULT_P0_MASK =
    (16'd1 << ST_IDLE) | (16'd1 << ST_DOORS) | (16'd1 << ST_DEPART);

  function automatic int default_idx(input int st);
    if (st >= 0 && st < 16 && DEFAULT_P0_MASK[st[3:0]]) return 0;
    return 1;
  endfunction

endpackage

// File: rtl/phase_map.sv
// State-to-preset map: register file with sync reset to defaults, one write and one read port.
module phase_map
  import train_pkg::*;
#(
  parameter int STATE_W   = 4,
  parameter int N_PRESETS = 4,
  parameter int IDX_W     = $clog2(N_PRESETS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [STATE_W-1:0] wr_state,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [STATE_W-1:0] rd_state,
  output logic [IDX_W-1:0]   rd_idx
);

  localparam int DEPTH = 2 ** STATE_W;

  logic [IDX_W-1:0] map_q [DEPTH];
  logic [IDX_W-1:0] wr_clamped;

  // Clamping is only needed when the index field can encode non-existent presets.
  if ((2 ** IDX_W) > N_PRESETS) begin : g_clamp
    assign wr_clamped = (wr_idx > IDX_W'(N_PRESETS - 1)) ? IDX_W'(N_PRESETS - 1) : wr_idx;
  end else begin : g_no_clamp
    assign wr_clamped = wr_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        map_q[i] <= IDX_W'(default_idx(i));
      end
    end else if (we) begin
      map_q[wr_state] <= wr_clamped;
    end
  end

  assign rd_idx = map_q[rd_state];

endmodule

// File: rtl/phase_timer.sv
// Per-state phase timer: loads a mapped preset on each state change and counts it down on tick.
// Optional freeze input enabled by defining PHASE_TIMER_HOLD_EN.
module phase_timer
  import train_pkg::*;
#(
  parameter int WIDTH     = TIME_W,
  parameter int STATE_W   = 4,
  parameter int N_PRESETS = 4,
  parameter int IDX_W     = $clog2(N_PRESETS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STATE_W-1:0]         present_state,
  input  logic [N_PRESETS*WIDTH-1:0] presets,
  input  logic                       tick,
  input  logic                       hold,
  input  logic                       cfg_we,
  input  logic [STATE_W-1:0]         cfg_state,
  input  logic [IDX_W-1:0]           cfg_idx,
  output logic [WIDTH-1:0]           tout,
  output logic [WIDTH-1:0]           remaining,
  output logic                       running,
  output logic                       expired
);

  logic [STATE_W-1:0] state_q;
  logic               load_pend;
  logic [IDX_W-1:0]   sel;
  logic [WIDTH-1:0]   preset_val;
  logic               load;
  logic               hold_act;
  logic               count_en;

  phase_map #(
    .STATE_W  (STATE_W),
    .N_PRESETS(N_PRESETS),
    .IDX_W    (IDX_W)
  ) u_map (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we),
    .wr_state(cfg_state),
    .wr_idx  (cfg_idx),
    .rd_state(present_state),
    .rd_idx  (sel)
  );

`ifdef PHASE_TIMER_HOLD_EN
  assign hold_act = hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign hold_act    = 1'b0;
`endif

  assign preset_val = presets[sel*WIDTH +: WIDTH];
  assign load       = (present_state != state_q) || load_pend;
  assign count_en   = !hold_act && tick && (remaining != '0);
  assign running    = (remaining != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= '0;
      load_pend <= 1'b1;
      tout      <= '0;
      remaining <= '0;
      expired   <= 1'b0;
    end else begin
      state_q <= present_state;
      expired <= 1'b0;
      if (load) begin
        remaining <= preset_val;
        tout      <= preset_val;
        load_pend <= 1'b0;
        // A zero-length phase still reports one expiry so the controller advances.
        expired   <= (preset_val == '0);
      end else if (count_en) begin
        remaining <= remaining - WIDTH'(1);
        expired   <= (remaining == WIDTH'(1));
      end
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer: vector table plus hand-written multi-cycle sequences.
module tb_phase_timer;
  localparam int WIDTH = 19;
  localparam int STATE_W = 4;
  localparam int N_PRESETS = 4;
  localparam int IDX_W = 2;

`ifdef PHASE_TIMER_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic [STATE_W-1:0]         present_state;
  logic [N_PRESETS*WIDTH-1:0] presets;
  logic                       tick;
  logic                       hold;
  logic                       cfg_we;
  logic [STATE_W-1:0]         cfg_state;
  logic [IDX_W-1:0]           cfg_idx;
  logic [WIDTH-1:0]           tout;
  logic [WIDTH-1:0]           remaining;
  logic                       running;
  logic                       expired;

  phase_timer #(.WIDTH(WIDTH), .STATE_W(STATE_W), .N_PRESETS(N_PRESETS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .present_state(present_state), .presets(presets),
    .tick(tick), .hold(hold), .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_idx(cfg_idx),
    .tout(tout), .remaining(remaining), .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] st;
    logic       tk;
    logic       hd;
    logic       we;
    logic [3:0] cs;
    logic [1:0] ci;
    int         e_tout;
    int         e_rem;
    logic       e_exp;
    string      name;
  } vec_t;

  typedef struct {
    int    e_tout;
    int    e_rem;
    logic  e_run;
    logic  e_exp;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic set_preset(input int k, input int val);
    presets[k*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  task automatic check_field(input string name, input string field, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s %s got=%0d want=%0d", name, field, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input logic r, input logic [3:0] st, input logic tk, input logic hd,
                       input logic we, input logic [3:0] cs, input logic [1:0] ci,
                       input int e_tout, input int e_rem, input logic e_exp, input string name);
    exp_t e;
    rst = r; present_state = st; tick = tk; hold = hd;
    cfg_we = we; cfg_state = cs; cfg_idx = ci;
    e.e_tout = e_tout; e.e_rem = e_rem; e.e_run = (e_rem != 0); e.e_exp = e_exp; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_field(e.name, "tout", int'(tout), e.e_tout);
    check_field(e.name, "remaining", int'(remaining), e.e_rem);
    check_field(e.name, "running", int'(running), int'(e.e_run));
    check_field(e.name, "expired", int'(expired), int'(e.e_exp));
  endtask

  task automatic add(input logic r, input logic [3:0] st, input logic tk, input logic we,
                     input logic [3:0] cs, input logic [1:0] ci,
                     input int e_tout, input int e_rem, input logic e_exp, input string name);
    vec_t v;
    v.r = r; v.st = st; v.tk = tk; v.hd = 1'b0; v.we = we; v.cs = cs; v.ci = ci;
    v.e_tout = e_tout; v.e_rem = e_rem; v.e_exp = e_exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; present_state = '0; tick = 0; hold = 0; cfg_we = 0; cfg_state = '0; cfg_idx = '0;
    presets = '0;
    set_preset(0, 100); set_preset(1, 50); set_preset(2, 7); set_preset(3, 0);
    #2;

    //   rst st tk we cs ci  tout rem exp
    add(1, 0, 0, 0, 0, 0,    0,   0, 0, "reset0");
    add(1, 0, 1, 0, 0, 0,    0,   0, 0, "reset1");
    add(0, 0, 0, 0, 0, 0,  100, 100, 0, "first_load");
    add(0, 0, 1, 0, 0, 0,  100,  99, 0, "tick99");
    add(0, 0, 1, 0, 0, 0,  100,  98, 0, "tick98");
    add(0, 1, 1, 0, 0, 0,   50,  50, 0, "load_over_tick");
    add(0, 1, 1, 0, 0, 0,   50,  49, 0, "tick49");
    add(0, 1, 0, 1, 2, 3,   50,  49, 0, "cfg_write");
    add(0, 2, 0, 0, 0, 0,    0,   0, 1, "zero_preset");
    add(0, 2, 0, 0, 0, 0,    0,   0, 0, "zero_no_refire");
    add(0, 2, 1, 0, 0, 0,    0,   0, 0, "zero_tick");
    add(0, 3, 0, 0, 0, 0,  100, 100, 0, "default_st3");
    add(0, 5, 0, 0, 0, 0,   50,  50, 0, "default_st5");
    add(0, 5, 1, 1, 5, 2,   50,  49, 0, "cfg_current");
    add(0, 6, 0, 0, 0, 0,   50,  50, 0, "default_st6");
    add(0, 5, 0, 0, 0, 0,    7,   7, 0, "new_map_st5");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].st, vecs[i].tk, vecs[i].hd, vecs[i].we, vecs[i].cs, vecs[i].ci,
            vecs[i].e_tout, vecs[i].e_rem, vecs[i].e_exp, vecs[i].name);
    end

    // Full 50-tick countdown with a single expiry pulse, then hold at zero.
    apply(0, 1, 0, 0, 0, 0, 0, 50, 50, 0, "cd_load");
    for (int i = 1; i <= 50; i++) begin
      apply(0, 1, 1, 0, 0, 0, 0, 50, 50 - i, (i == 50), "cd_tick");
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, 0, 0, 0, 0, 50, 0, 0, "cd_after");
    end

    // State change coinciding with a tick at remaining=5.
    apply(0, 5, 0, 0, 0, 0, 0, 7, 7, 0, "b_load");
    apply(0, 5, 1, 0, 0, 0, 0, 7, 6, 0, "b_tick6");
    apply(0, 5, 1, 0, 0, 0, 0, 7, 5, 0, "b_tick5");
    apply(0, 0, 1, 0, 0, 0, 0, 100, 100, 0, "b_reload");

    // Hold behaviour at remaining=20.
    set_preset(3, 20);
    apply(0, 2, 0, 0, 0, 0, 0, 20, 20, 0, "h_load");
    for (int i = 1; i <= 10; i++) begin
      apply(0, 2, 1, 1, 0, 0, 0, 20, HOLD_ON ? 20 : 20 - i, 0, "h_tick");
    end
    apply(0, 0, 1, 1, 0, 0, 0, 100, 100, 0, "h_reload");
    hold = 1'b0;

    // Reset mid-countdown restores outputs and map defaults.
    set_preset(3, 3);
    apply(0, 2, 0, 0, 0, 0, 0, 3, 3, 0, "r_load");
    apply(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, "r_assert");
    apply(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, "r_hold");
    apply(0, 3, 0, 0, 0, 0, 0, 100, 100, 0, "r_st3_default");
    apply(0, 2, 0, 0, 0, 0, 0, 50, 50, 0, "r_st2_default");
    apply(0, 5, 0, 0, 0, 0, 0, 50, 50, 0, "r_st5_default");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
